// File: rtl/mynios2_sysid_checker_if.sv
// Avalon-MM read channel between the sysid checker
// (master) and the system-ID control_slave (slave).
interface mynios2_sysid_checker_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdatavalid,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdatavalid,
    output avm_readdata
  );
endinterface

// File: rtl/mynios2_sysid_checker.sv
// Reads sysid ID and timestamp words, compares them with
// build-time values and reports pass / fail / timeout.
module mynios2_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'd12345678,
  parameter logic [31:0] EXPECTED_TS    = 32'd1391926578,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  mynios2_sysid_checker_if.master avm,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE,
    ID_REQ,
    ID_WAIT,
    TS_REQ,
    TS_WAIT,
    DONE
  } state_e;

  localparam logic [16:0] TMO = 17'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        tmo_q, tmo_d;
  logic        pass_q, pass_d;
  logic [31:0] id_val_q, id_val_d;
  logic [31:0] ts_val_q, ts_val_d;
  logic        id_cap_q, id_cap_d;
  logic        ts_cap_q, ts_cap_d;

  logic [16:0] cnt_inc;
  logic [15:0] cnt_sat;
  logic        hit;
  logic        start_acc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    tmo_d     = tmo_q;
    id_val_d  = id_val_q;
    ts_val_d  = ts_val_q;
    id_cap_d  = id_cap_q;
    ts_cap_d  = ts_cap_q;
    start_acc = 1'b0;
    cnt_inc   = {1'b0, cnt_q} + 17'd1;
    cnt_sat   = cnt_inc[16] ? 16'hffff
                            : cnt_inc[15:0];
    hit       = (cnt_inc >= TMO);

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = ID_REQ;
          cnt_d     = '0;
          done_d    = 1'b0;
          tmo_d     = 1'b0;
          id_val_d  = '0;
          ts_val_d  = '0;
          id_cap_d  = 1'b0;
          ts_cap_d  = 1'b0;
        end else if (state_q == DONE) begin
          done_d = 1'b1;
        end
      end
      ID_REQ, TS_REQ: begin
        cnt_d = cnt_sat;
        if (hit) begin
          state_d = DONE;
          tmo_d   = 1'b1;
          done_d  = 1'b1;
        end else if (!avm.avm_waitrequest) begin
          state_d = (state_q == ID_REQ) ? ID_WAIT
                                        : TS_WAIT;
        end
      end
      ID_WAIT: begin
        cnt_d = cnt_sat;
        // data arriving on the limit cycle still wins
        if (avm.avm_readdatavalid) begin
          id_val_d = avm.avm_readdata;
          id_cap_d = 1'b1;
          if (CHECK_TS) begin
            state_d = TS_REQ;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
          end
        end else if (hit) begin
          state_d = DONE;
          tmo_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      TS_WAIT: begin
        cnt_d = cnt_sat;
        if (avm.avm_readdatavalid) begin
          ts_val_d = avm.avm_readdata;
          ts_cap_d = 1'b1;
          state_d  = DONE;
        end else if (hit) begin
          state_d = DONE;
          tmo_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    id_ok_d = id_cap_q &&
              (id_val_q == EXPECTED_ID);
    ts_ok_d = CHECK_TS ?
              (ts_cap_q &&
               (ts_val_q == EXPECTED_TS)) :
              (state_q != IDLE);
    if (start_acc) begin
      id_ok_d = 1'b0;
      ts_ok_d = 1'b0;
    end
    pass_d = done_d & id_ok_d & ts_ok_d & ~tmo_d;
    busy_d = state_d inside {ID_REQ, ID_WAIT,
                             TS_REQ, TS_WAIT};
    read_d = state_d inside {ID_REQ, TS_REQ};
    addr_d = state_d inside {TS_REQ, TS_WAIT};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      read_q   <= 1'b0;
      addr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      tmo_q    <= 1'b0;
      pass_q   <= 1'b0;
      id_val_q <= '0;
      ts_val_q <= '0;
      id_cap_q <= 1'b0;
      ts_cap_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      read_q   <= read_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      id_ok_q  <= id_ok_d;
      ts_ok_q  <= ts_ok_d;
      tmo_q    <= tmo_d;
      pass_q   <= pass_d;
      id_val_q <= id_val_d;
      ts_val_q <= ts_val_d;
      id_cap_q <= id_cap_d;
      ts_cap_q <= ts_cap_d;
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign timeout         = tmo_q;
  assign pass            = pass_q;
  assign id_value        = id_val_q;
  assign ts_value        = ts_val_q;

endmodule

// File: doc/mynios2_sysid_checker.md
Name: mynios2_sysid_checker

Overview:
- Avalon-MM read master that sits directly in front of the system-ID slave's control_slave port and consumes its 32-bit readdata.
- On each start pulse it reads word 0 (ID) and word 1 (timestamp), compares both against build-time expected values, and reports pass, fail or timeout.
- The result flags and captured values go to a status register bank and the boot-gating logic, so the FPGA image can be rejected before the Nios II software runs.

Parameters:
- EXPECTED_ID, 32'd12345678, value required at address 0.
- EXPECTED_TS, 32'd1391926578, value required at address 1.
- CHECK_TS, 1, when 0 skip the timestamp read; ts_ok is then forced to 1.
- TIMEOUT_CYCLES, 255, maximum cycles per read from first read assertion to readdatavalid (range 1..65535).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to run a check.
- avm_address  out  1  word address to the sysid slave (0 = ID, 1 = timestamp).
- avm_read  out  1  Avalon read strobe.
- avm_waitrequest  in  1  slave stall; tie to 0 when the slave has no stall.
- avm_readdatavalid  in  1  read data valid.
- avm_readdata  in  32  slave read data.
- busy  out  1  check in progress.
- done  out  1  sticky; set when a check completes.
- id_ok  out  1  captured ID equals EXPECTED_ID.
- ts_ok  out  1  captured timestamp equals EXPECTED_TS (or CHECK_TS = 0).
- timeout  out  1  a read exceeded TIMEOUT_CYCLES.
- pass  out  1  done & id_ok & ts_ok & !timeout.
- id_value  out  32  captured ID word.
- ts_value  out  32  captured timestamp word.

Behaviour:
- Reset: reset_n is asynchronous and active-low. While it is low, all outputs are 0, the FSM is in IDLE and the timeout counter is 0.
- Reset mid-operation aborts the check immediately. No pending read is tracked after reset.
- FSM states: IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE. All outputs are registered.
- IDLE or DONE with start=1:
  - clear done, id_ok, ts_ok, timeout, id_value and ts_value;
  - next state ID_REQ with avm_address=0 and avm_read=1.
- start is ignored while busy (ID_REQ, ID_WAIT, TS_REQ, TS_WAIT).
- xx_REQ states:
  - avm_read and avm_address are held stable while avm_waitrequest=1.
  - When avm_read=1 and avm_waitrequest=0 the read is accepted. The next cycle has avm_read=0 and the state moves to xx_WAIT.
- xx_WAIT states:
  - on avm_readdatavalid=1, capture avm_readdata.
  - ID_WAIT goes to TS_REQ (avm_address=1) if CHECK_TS=1, else to DONE.
  - TS_WAIT goes to DONE.
- avm_readdatavalid is ignored outside the WAIT states; there is no spurious capture.
- Latency: minimum 2 cycles from an accepted read to capture (accept cycle, then readdatavalid in the following cycle or later).
  - With waitrequest=0 and readdatavalid one cycle after accept, a full check takes 6 cycles from start to done=1 (ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE).
- Compare: id_ok and ts_ok are registered the cycle after capture and are valid when done=1. The comparison is a full 32-bit equality.
- Timeout counter:
  - 16 bits; cleared when entering each REQ state and incremented every cycle spent in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES without capture: avm_read=0, timeout=1, ok flag of the unfinished read = 0, go to DONE.
  - The counter saturates and never wraps.
- Simultaneous events:
  - readdatavalid in the same cycle the counter hits TIMEOUT_CYCLES counts as a capture, not a timeout.
  - start in the same cycle as entry to DONE is ignored; start is accepted from the first cycle spent in DONE.
- busy = 1 in REQ and WAIT states only.
- done, pass, flags and values hold in DONE until the next accepted start or reset.

Test Plan:
1. Zero-wait slave returning 12345678 then 1391926578, start pulse -> avm_address sequence 0 then 1; done=1 six cycles after start; id_ok=1, ts_ok=1, pass=1, timeout=0.
2. Slave returns 0x00000001 for ID -> id_ok=0, ts_ok=1, pass=0, id_value=0x00000001.
3. avm_waitrequest held high 5 cycles on the ID read -> avm_read and avm_address stay stable all 5 cycles; a single accept; result identical to scenario 1, only later.
4. TIMEOUT_CYCLES=8, readdatavalid never asserted -> avm_read drops; timeout=1, done=1, pass=0 eight cycles after the first avm_read; readdatavalid at exactly cycle 8 instead -> capture, timeout=0.
5. start re-pulsed while busy, plus a stray readdatavalid in ID_REQ -> no restart and no capture; a later start in DONE clears all flags and reruns the check.
6. reset_n asserted low during TS_WAIT -> all outputs 0 asynchronously; after release, start runs a clean check; CHECK_TS=0 build -> no address-1 read, ts_ok=1.
